// File: rtl/fast_pkg.sv
// Shared constants for the FAST-9 corner detector pipeline.
package fast_pkg;

    localparam int PIXEL_WIDTH  = 8;
    localparam int CIRCLE_N     = 16;
    localparam int ARC_LEN      = 9;
    localparam int SCORE_WIDTH  = 12;
    localparam int FAST_LATENCY = 8;

endpackage

// File: rtl/fast_arc_detect.sv
// Flags a run of ARC_LEN set bits anywhere on the circular mask.
module fast_arc_detect
    import fast_pkg::*;
(
    input  logic [CIRCLE_N-1:0] mask_i,
    output logic                arc_o
);

    // Unrolled circle: enough wrap-around bits for every start position.
    logic [CIRCLE_N+ARC_LEN-2:0] ring;

    assign ring = {mask_i[ARC_LEN-2:0], mask_i};

    always_comb begin
        arc_o = 1'b0;
        for (int i = 0; i < CIRCLE_N; i++) begin
            if (&ring[i +: ARC_LEN]) arc_o = 1'b1;
        end
    end

endmodule

// File: rtl/fast_corner_score.sv
// FAST-9 corner decision and score, 8-stage pipeline:
// threshold/mask, arc, corner delay, four adder levels, max.
module fast_corner_score #(
    parameter int PIXEL_WIDTH = fast_pkg::PIXEL_WIDTH,
    parameter int SCORE_WIDTH = fast_pkg::SCORE_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       ce,
    input  logic [PIXEL_WIDTH-1:0]     threshold,
    input  logic                       patch_vld,
    input  logic [PIXEL_WIDTH-1:0]     center,
    input  logic [16*PIXEL_WIDTH-1:0]  circle,
    output logic                       out_vld,
    output logic                       is_corner,
    output logic [SCORE_WIDTH-1:0]     score
);

    import fast_pkg::*;

    localparam int W = PIXEL_WIDTH;

    typedef logic [W-1:0] pix_t;

    logic [W:0]          hi_d;
    logic [W:0]          lo_d;
    logic [CIRCLE_N-1:0] bm_d;
    logic [CIRCLE_N-1:0] dm_d;
    pix_t                bd_d [CIRCLE_N];
    pix_t                dd_d [CIRCLE_N];

    logic [CIRCLE_N-1:0] bm1_q;
    logic [CIRCLE_N-1:0] dm1_q;
    pix_t                bd1_q [CIRCLE_N];
    pix_t                dd1_q [CIRCLE_N];
    pix_t                bd2_q [CIRCLE_N];
    pix_t                dd2_q [CIRCLE_N];
    pix_t                bd3_q [CIRCLE_N];
    pix_t                dd3_q [CIRCLE_N];

    logic [W:0]   bs4_d [8];
    logic [W:0]   ds4_d [8];
    logic [W:0]   bs4_q [8];
    logic [W:0]   ds4_q [8];
    logic [W+1:0] bs5_d [4];
    logic [W+1:0] ds5_d [4];
    logic [W+1:0] bs5_q [4];
    logic [W+1:0] ds5_q [4];
    logic [W+2:0] bs6_d [2];
    logic [W+2:0] ds6_d [2];
    logic [W+2:0] bs6_q [2];
    logic [W+2:0] ds6_q [2];
    logic [W+3:0] bs7_d;
    logic [W+3:0] ds7_d;
    logic [W+3:0] bs7_q;
    logic [W+3:0] ds7_q;
    logic [W+3:0] max_d;

    logic barc;
    logic darc;
    logic c2_q;
    logic c3_q;
    logic c4_q;
    logic c5_q;
    logic c6_q;
    logic c7_q;

    logic                    corner_d;
    logic                    corner_q;
    logic [SCORE_WIDTH-1:0]  score_d;
    logic [SCORE_WIDTH-1:0]  score_q;
    logic [FAST_LATENCY-1:0] vld_q;

    // Bounds kept one bit wider: hi overflow means nothing is bright,
    // lo borrow (lo_d[W]) means nothing is dark.
    always_comb begin
        hi_d = {1'b0, center} + {1'b0, threshold};
        lo_d = {1'b0, center} - {1'b0, threshold};
        for (int i = 0; i < CIRCLE_N; i++) begin
            bm_d[i] = {1'b0, circle[i*W +: W]} > hi_d;
            dm_d[i] = !lo_d[W] && (circle[i*W +: W] < lo_d[W-1:0]);
            bd_d[i] = bm_d[i] ? W'({1'b0, circle[i*W +: W]} - hi_d) : '0;
            dd_d[i] = dm_d[i] ? lo_d[W-1:0] - circle[i*W +: W] : '0;
        end
    end

    fast_arc_detect u_arc_bright (
        .mask_i (bm1_q),
        .arc_o  (barc)
    );

    fast_arc_detect u_arc_dark (
        .mask_i (dm1_q),
        .arc_o  (darc)
    );

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            bs4_d[i] = {1'b0, bd3_q[2*i]} + {1'b0, bd3_q[2*i+1]};
            ds4_d[i] = {1'b0, dd3_q[2*i]} + {1'b0, dd3_q[2*i+1]};
        end
        for (int i = 0; i < 4; i++) begin
            bs5_d[i] = {1'b0, bs4_q[2*i]} + {1'b0, bs4_q[2*i+1]};
            ds5_d[i] = {1'b0, ds4_q[2*i]} + {1'b0, ds4_q[2*i+1]};
        end
        for (int i = 0; i < 2; i++) begin
            bs6_d[i] = {1'b0, bs5_q[2*i]} + {1'b0, bs5_q[2*i+1]};
            ds6_d[i] = {1'b0, ds5_q[2*i]} + {1'b0, ds5_q[2*i+1]};
        end
        bs7_d    = {1'b0, bs6_q[0]} + {1'b0, bs6_q[1]};
        ds7_d    = {1'b0, ds6_q[0]} + {1'b0, ds6_q[1]};
        max_d    = (bs7_q >= ds7_q) ? bs7_q : ds7_q;
        corner_d = vld_q[FAST_LATENCY-2] & c7_q;
        score_d  = corner_d ? SCORE_WIDTH'(max_d) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q    <= '0;
            bm1_q    <= '0;
            dm1_q    <= '0;
            bd1_q    <= '{default: '0};
            dd1_q    <= '{default: '0};
            bd2_q    <= '{default: '0};
            dd2_q    <= '{default: '0};
            bd3_q    <= '{default: '0};
            dd3_q    <= '{default: '0};
            bs4_q    <= '{default: '0};
            ds4_q    <= '{default: '0};
            bs5_q    <= '{default: '0};
            ds5_q    <= '{default: '0};
            bs6_q    <= '{default: '0};
            ds6_q    <= '{default: '0};
            bs7_q    <= '0;
            ds7_q    <= '0;
            c2_q     <= 1'b0;
            c3_q     <= 1'b0;
            c4_q     <= 1'b0;
            c5_q     <= 1'b0;
            c6_q     <= 1'b0;
            c7_q     <= 1'b0;
            corner_q <= 1'b0;
            score_q  <= '0;
        end else if (ce) begin
            vld_q    <= {vld_q[FAST_LATENCY-2:0], patch_vld};
            bm1_q    <= bm_d;
            dm1_q    <= dm_d;
            bd1_q    <= bd_d;
            dd1_q    <= dd_d;
            bd2_q    <= bd1_q;
            dd2_q    <= dd1_q;
            bd3_q    <= bd2_q;
            dd3_q    <= dd2_q;
            bs4_q    <= bs4_d;
            ds4_q    <= ds4_d;
            bs5_q    <= bs5_d;
            ds5_q    <= ds5_d;
            bs6_q    <= bs6_d;
            ds6_q    <= ds6_d;
            bs7_q    <= bs7_d;
            ds7_q    <= ds7_d;
            c2_q     <= barc | darc;
            c3_q     <= c2_q;
            c4_q     <= c3_q;
            c5_q     <= c4_q;
            c6_q     <= c5_q;
            c7_q     <= c6_q;
            corner_q <= corner_d;
            score_q  <= score_d;
        end
    end

    assign out_vld   = vld_q[FAST_LATENCY-1];
    assign is_corner = corner_q;
    assign score     = score_q;

endmodule

// File: tb/tb_fast_corner_score.sv
// Directed and streamed checks of fast_corner_score against
// hand-computed values and a small behavioural model.
module tb_fast_corner_score;

    localparam int LAT = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         ce;
    logic [7:0]   threshold;
    logic         patch_vld;
    logic [7:0]   center;
    logic [127:0] circle;
    logic         out_vld;
    logic         is_corner;
    logic [11:0]  score;

    int checks   = 0;
    int failures = 0;

    logic ev [LAT];
    logic ec [LAT];
    int   es [LAT];
    logic cur_c;
    int   cur_s;

    always #5 clk = ~clk;

    fast_corner_score dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ce        (ce),
        .threshold (threshold),
        .patch_vld (patch_vld),
        .center    (center),
        .circle    (circle),
        .out_vld   (out_vld),
        .is_corner (is_corner),
        .score     (score)
    );

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] flat(input int v);
        logic [127:0] c;
        for (int i = 0; i < 16; i++) c[i*8 +: 8] = 8'(v);
        return c;
    endfunction

    function automatic logic [127:0] setr(input logic [127:0] c,
                                          input int a, input int b,
                                          input int v);
        logic [127:0] r;
        r = c;
        for (int i = a; i <= b; i++) r[i*8 +: 8] = 8'(v);
        return r;
    endfunction

    task automatic model(input int c, input int t,
                         input logic [127:0] circ,
                         output logic corner, output int sc);
        int p;
        int bs;
        int ds;
        logic [15:0] bm;
        logic [15:0] dm;
        logic run_b;
        logic run_d;
        bs = 0;
        ds = 0;
        bm = '0;
        dm = '0;
        for (int i = 0; i < 16; i++) begin
            p = int'(circ[i*8 +: 8]);
            if (p > c + t) begin
                bm[i] = 1'b1;
                bs += p - c - t;
            end
            if (p < c - t) begin
                dm[i] = 1'b1;
                ds += c - t - p;
            end
        end
        corner = 1'b0;
        for (int s = 0; s < 16; s++) begin
            run_b = 1'b1;
            run_d = 1'b1;
            for (int k = 0; k < 9; k++) begin
                if (!bm[(s + k) % 16]) run_b = 1'b0;
                if (!dm[(s + k) % 16]) run_d = 1'b0;
            end
            if (run_b || run_d) corner = 1'b1;
        end
        sc = corner ? ((bs > ds) ? bs : ds) : 0;
    endtask

    task automatic clear_model();
        for (int i = 0; i < LAT; i++) begin
            ev[i] = 1'b0;
            ec[i] = 1'b0;
            es[i] = 0;
        end
    endtask

    task automatic check_out(input string tag);
        check($sformatf("%s.vld", tag), int'(out_vld), int'(ev[LAT-1]));
        check($sformatf("%s.crn", tag), int'(is_corner), int'(ec[LAT-1]));
        check($sformatf("%s.scr", tag), int'(score), es[LAT-1]);
    endtask

    task automatic tick(input logic ce_v, input string tag);
        ce = ce_v;
        @(posedge clk);
        if (ce_v) begin
            for (int i = LAT - 1; i > 0; i--) begin
                ev[i] = ev[i-1];
                ec[i] = ec[i-1];
                es[i] = es[i-1];
            end
            ev[0] = patch_vld;
            ec[0] = patch_vld & cur_c;
            es[0] = (patch_vld && cur_c) ? cur_s : 0;
        end
        #1;
        check_out(tag);
    endtask

    task automatic drive(input int c, input int t, input logic [127:0] circ,
                         input logic exp_c, input int exp_s,
                         input string tag);
        center    = 8'(c);
        threshold = 8'(t);
        circle    = circ;
        patch_vld = 1'b1;
        cur_c     = exp_c;
        cur_s     = exp_s;
        tick(1'b1, tag);
    endtask

    initial begin
        int c;
        int t;
        int s;
        int len;
        int off;
        int d;
        int v;
        logic br;

        rst_n     = 1'b0;
        ce        = 1'b1;
        patch_vld = 1'b1;
        center    = 8'd0;
        threshold = 8'd0;
        circle    = flat(255);
        cur_c     = 1'b0;
        cur_s     = 0;
        clear_model();

        repeat (3) @(posedge clk);
        #1;
        check("rst.vld", int'(out_vld), 0);
        check("rst.crn", int'(is_corner), 0);
        check("rst.scr", int'(score), 0);
        rst_n     = 1'b1;
        patch_vld = 1'b0;

        drive(100, 20, flat(100), 1'b0, 0, "flat");
        drive(100, 20, setr(flat(100), 0, 8, 150), 1'b1, 270, "arc9");
        drive(100, 20, setr(setr(flat(100), 12, 15, 40), 0, 4, 40),
              1'b1, 360, "wrap");
        drive(100, 20, setr(flat(100), 0, 7, 150), 1'b0, 0, "arc8");
        drive(100, 20, setr(setr(flat(100), 0, 7, 150), 8, 8, 120),
              1'b0, 0, "arc8eq");
        drive(250, 10, flat(255), 1'b0, 0, "sat_hi");
        drive(5, 10, flat(0), 1'b0, 0, "sat_lo");
        drive(100, 0, flat(101), 1'b1, 16, "t0");
        drive(100, 20, setr(setr(flat(100), 0, 8, 10), 9, 15, 255),
              1'b1, 945, "mixmax");
        drive(0, 0, flat(255), 1'b1, 4080, "full");
        patch_vld = 1'b0;
        tick(1'b1, "bubble");
        drive(100, 20, setr(flat(100), 7, 15, 150), 1'b1, 270, "arc9b");
        patch_vld = 1'b0;
        repeat (3) tick(1'b0, "hold");
        repeat (LAT + 2) tick(1'b1, "drain");

        for (int k = 0; k < 20; k++) begin
            repeat ($urandom_range(0, 2)) tick(1'b0, "s_hold");
            c   = int'($urandom_range(20, 235));
            t   = int'($urandom_range(0, 30));
            s   = int'($urandom_range(0, 15));
            len = int'($urandom_range(5, 12));
            off = int'($urandom_range(0, 40));
            br  = 1'($urandom_range(0, 1));
            for (int i = 0; i < 16; i++) begin
                d = (i - s + 16) % 16;
                if (d < len) v = br ? c + t + off : c - t - off;
                else v = c + int'($urandom_range(0, 20)) - 10;
                if (v < 0) v = 0;
                if (v > 255) v = 255;
                circle[i*8 +: 8] = 8'(v);
            end
            center    = 8'(c);
            threshold = 8'(t);
            patch_vld = ($urandom_range(0, 3) != 0);
            model(c, t, circle, cur_c, cur_s);
            tick(1'b1, "stream");
            if (k == 10) begin
                #2;
                rst_n = 1'b0;
                #1;
                check("midrst.vld", int'(out_vld), 0);
                check("midrst.crn", int'(is_corner), 0);
                check("midrst.scr", int'(score), 0);
                rst_n = 1'b1;
                clear_model();
            end
        end
        patch_vld = 1'b0;
        repeat (LAT + 4) tick(1'b1, "s_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
